// File: rtl/jericalla_pkg.sv
// Shared widths, ALU opcode encoding and the constant ROM contents for the
// jericalla datapath.
package jericalla_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SRA  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_NOR  = 4'b1100
  } alu_op_e;

  // ROM word i holds 10*i; the largest entry (150) fits easily in any sane width.
  function automatic logic [DEF_DATA_W-1:0] rom_word(input logic [3:0] idx);
    return DEF_DATA_W'(idx) * DEF_DATA_W'(10);
  endfunction

endpackage

// File: rtl/jericalla.sv
// Thin alias wrapper around jericalla_datapath, which holds the datapath itself.
// Exposes the same parameters and ports under the module name jericalla.
module jericalla
  import jericalla_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [16:0]       instruccion,
  output logic [DATA_W-1:0] salida,
  output logic              Zflag
);

  jericalla_datapath #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_dp (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruccion (instruccion),
    .salida      (salida),
    .Zflag       (Zflag)
  );

endmodule

// File: rtl/jericalla_alu.sv
// Combinational ALU: two operands and a 4-bit opcode in, result and zero flag out.
module jericalla_alu
  import jericalla_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [3:0]        op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  always_comb begin
    result_o = '0;
    case (alu_op_e'(op_i))
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_ADD:  result_o = a_i + b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_SLL:  result_o = a_i << shamt;
      OP_SRL:  result_o = a_i >> shamt;
      OP_SUB:  result_o = a_i - b_i;
      OP_SLT:  result_o = ($signed(a_i) < $signed(b_i)) ? DATA_W'(1) : '0;
      OP_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
      OP_SLTU: result_o = (a_i < b_i) ? DATA_W'(1) : '0;
      OP_NOR:  result_o = ~(a_i | b_i);
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/jericalla_datapath.sv
// ROM -> ALU -> RAM datapath: two ROM operands feed the ALU, whose result can be
// written into a 16-word RAM that is read back combinationally on salida.
module jericalla_datapath
  import jericalla_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [16:0]       instruccion,
  output logic [DATA_W-1:0] salida,
  output logic              Zflag
);

  localparam int RAM_DEPTH = 1 << ADDR_W;

  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        alu_op;
  logic [3:0]        rom_addr_a;
  logic [3:0]        rom_addr_b;
  logic              wr_en;

  assign ram_addr   = ADDR_W'(instruccion[16:13]);
  assign alu_op     = instruccion[12:9];
  assign rom_addr_a = instruccion[8:5];
  assign rom_addr_b = instruccion[4:1];
  assign wr_en      = instruccion[0];

  logic [DATA_W-1:0] rom_a;
  logic [DATA_W-1:0] rom_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  assign rom_a = DATA_W'(rom_word(rom_addr_a));
  assign rom_b = DATA_W'(rom_word(rom_addr_b));

  jericalla_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a_i      (rom_a),
    .b_i      (rom_b),
    .op_i     (alu_op),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  // The flag depends only on the constant ROM and the opcode, so reset never touches it.
  assign Zflag = alu_zero;

  logic [DATA_W-1:0] mem_q [RAM_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[ram_addr] <= alu_result;
    end
  end

  assign salida = mem_q[ram_addr];

endmodule

// File: tb/tb_jericalla_datapath.sv
// Directed bench for jericalla_datapath: stimulus queues expected salida/Zflag,
// an independent monitor compares them on the falling clock edge.
module tb_jericalla_datapath;

  localparam int OP_AND  = 0;
  localparam int OP_OR   = 1;
  localparam int OP_ADD  = 2;
  localparam int OP_XOR  = 3;
  localparam int OP_SLL  = 4;
  localparam int OP_SRL  = 5;
  localparam int OP_SUB  = 6;
  localparam int OP_SLT  = 7;
  localparam int OP_SRA  = 8;
  localparam int OP_SLTU = 9;
  localparam int OP_NOR  = 12;
  localparam int OP_UNU  = 15;

  logic        clk;
  logic        rst_n;
  logic [16:0] instruccion;
  logic [31:0] salida;
  logic        Zflag;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_sal_q[$];
  logic        exp_z_q[$];
  string       exp_nm_q[$];

  jericalla_datapath #(
    .DATA_W (32),
    .ADDR_W (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruccion (instruccion),
    .salida      (salida),
    .Zflag       (Zflag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] mk(input int addr, input int op, input int a,
                                     input int b, input int en);
    return {4'(addr), 4'(op), 4'(a), 4'(b), 1'(en)};
  endfunction

  // Inputs change just after a rising edge; the monitor samples at the next falling edge.
  task automatic step(input logic rst_v, input logic [16:0] ins,
                      input logic [31:0] es, input logic ez, input string nm);
    @(posedge clk);
    #1;
    rst_n       = rst_v;
    instruccion = ins;
    exp_sal_q.push_back(es);
    exp_z_q.push_back(ez);
    exp_nm_q.push_back(nm);
  endtask

  initial begin : monitor
    logic [31:0] es;
    logic        ez;
    string       nm;
    forever begin
      @(negedge clk);
      while (exp_sal_q.size() > 0) begin
        es = exp_sal_q.pop_front();
        ez = exp_z_q.pop_front();
        nm = exp_nm_q.pop_front();
        checks++;
        if (salida !== es) begin
          errors++;
          $display("FAIL %s salida: got 0x%08h expected 0x%08h", nm, salida, es);
        end
        checks++;
        if (Zflag !== ez) begin
          errors++;
          $display("FAIL %s Zflag: got %0b expected %0b", nm, Zflag, ez);
        end
      end
    end
  end

  initial begin : stim
    int waited;
    rst_n       = 1'b0;
    instruccion = '0;

    // Writes must be suppressed while reset is held, flag still live.
    step(0, mk(2, OP_ADD, 4, 6, 1), 32'd0, 1'b0, "rst_wr_block");
    step(0, mk(2, OP_ADD, 4, 6, 1), 32'd0, 1'b0, "rst_wr_block2");

    for (int i = 0; i < 16; i++)
      step(1, mk(i, OP_AND, 0, 0, 0), 32'd0, 1'b1, "clear_read");

    step(1, mk(2, OP_ADD, 4, 6, 1),  32'd0,   1'b0, "add_wr_old");
    step(1, mk(2, OP_AND, 0, 0, 0),  32'd100, 1'b1, "add_rd");

    step(1, mk(3, OP_SUB, 3, 3, 1),  32'd0, 1'b1, "sub_eq_wr");
    step(1, mk(3, OP_AND, 0, 0, 0),  32'd0, 1'b1, "sub_eq_rd");
    step(1, mk(4, OP_SUB, 0, 1, 1),  32'd0, 1'b0, "sub_neg_wr");
    step(1, mk(4, OP_AND, 0, 0, 0),  32'hFFFF_FFF6, 1'b1, "sub_neg_rd");
    step(1, mk(5, OP_SLT, 0, 1, 1),  32'd0, 1'b0, "slt_wr");
    step(1, mk(5, OP_AND, 0, 0, 0),  32'd1, 1'b1, "slt_rd");
    step(1, mk(6, OP_SLTU, 1, 0, 1), 32'd0, 1'b1, "sltu0_wr");
    step(1, mk(6, OP_SLTU, 0, 1, 0), 32'd0, 1'b0, "sltu0_rd");
    step(1, mk(8, OP_XOR, 5, 3, 1),  32'd0, 1'b0, "xor_wr");
    step(1, mk(8, OP_SLL, 1, 10, 1), 32'd44, 1'b0, "xor_rd_sll_wr");
    step(1, mk(8, OP_SRL, 15, 13, 1), 32'd160, 1'b0, "sll_rd_srl_wr");
    step(1, mk(8, OP_SRA, 15, 13, 1), 32'd37, 1'b0, "srl_rd_sra_wr");
    step(1, mk(8, OP_NOR, 0, 0, 1),  32'd37, 1'b0, "sra_rd_nor_wr");
    step(1, mk(8, OP_AND, 15, 14, 1), 32'hFFFF_FFFF, 1'b0, "nor_rd_and_wr");
    step(1, mk(8, OP_AND, 0, 0, 0),  32'd132, 1'b1, "and_rd");

    step(1, mk(7, OP_ADD, 1, 1, 1),  32'd0,  1'b0, "pre_unused_wr");
    step(1, mk(7, OP_UNU, 5, 6, 1),  32'd20, 1'b1, "unused_wr");
    step(1, mk(7, OP_AND, 0, 0, 0),  32'd0,  1'b1, "unused_rd");

    step(1, mk(0, OP_ADD, 1, 2, 1),  32'd0,  1'b0, "addr0_wr");
    step(1, mk(0, OP_AND, 0, 0, 0),  32'd30, 1'b1, "addr0_rd");
    step(1, mk(2, OP_AND, 0, 0, 0),  32'd100, 1'b1, "addr2_kept");

    step(1, mk(15, OP_OR, 15, 1, 1), 32'd0,   1'b0, "or15_wr");
    step(1, mk(15, OP_AND, 0, 0, 0), 32'h9E,  1'b1, "or15_rd");
    step(0, mk(15, OP_AND, 0, 0, 0), 32'd0,   1'b1, "rst_async");
    step(0, mk(1, OP_ADD, 1, 1, 1),  32'd0,   1'b0, "rst_hold");
    step(1, mk(1, OP_ADD, 1, 1, 1),  32'd0,   1'b0, "first_wr");
    step(1, mk(1, OP_AND, 0, 0, 0),  32'd20,  1'b1, "first_rd");
    step(1, mk(2, OP_AND, 0, 0, 0),  32'd0,   1'b1, "addr2_cleared");

    waited = 0;
    while (exp_sal_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (exp_sal_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_sal_q.size());
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
